// File: rtl/mutex_pkg.sv
// ============================================================================
// mutex_pkg : shared types and helpers for the mutex_grant_n grant latch.
// Rev 1.0
// ============================================================================
`default_nettype none

package mutex_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mutex_grant_n_if.sv
// ============================================================================
// mutex_grant_n_if : request/grant bundle between requesters and the latch.
// Rev 1.0
// ============================================================================
`default_nettype none

interface mutex_grant_n_if #(
  parameter int N = 4
);
  localparam int ID_W = mutex_pkg::id_w(N);

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface

`default_nettype wire

// File: rtl/mutex_pick.sv
// ============================================================================
// mutex_pick : combinational first-eligible picker searching from i_start.
// Rev 1.0
// ============================================================================
`default_nettype none

module mutex_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  wire logic [N-1:0]    i_elig,
  input  wire logic [ID_W-1:0] i_start,
  output logic      [N-1:0]    o_onehot,
  output logic      [ID_W-1:0] o_idx,
  output logic                 o_any
);

  logic [ID_W:0] w_cand;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so start+k can exceed N-1 before wrapping.
      w_cand = {1'b0, i_start} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(N)) begin
        w_cand = w_cand - (ID_W+1)'(N);
      end
      if (!o_any && i_elig[w_cand[ID_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[ID_W-1:0];
      end
    end
  end

  assign o_onehot = o_any ? (N'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/mutex_grant_n.sv
// ============================================================================
// mutex_grant_n : N-channel first-come-wins grant latch with optional hold
// timeout. Define MUTEX_RR_EN for rotating tie-break priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module mutex_grant_n
  import mutex_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 0
) (
  input wire logic       clk,
  input wire logic       rst,
  mutex_grant_n_if.slave bus
);

  localparam int ID_W = id_w(N);

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_gnt, w_gnt_nxt;
  logic [ID_W-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [N-1:0]    r_mask, w_mask_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic [N-1:0]    w_elig;
  logic [N-1:0]    w_pick_oh;
  logic [ID_W-1:0] w_pick_id;
  logic [ID_W-1:0] w_start;
  logic            w_pick_any;
  logic            w_owner_req;
  logic            w_expire;
  logic            w_grant;

  assign w_elig      = bus.req & ~r_mask;
  assign w_owner_req = |(bus.req & r_gnt);
  assign w_grant     = (r_state == IDLE) && w_pick_any;

  mutex_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .i_elig   (w_elig),
    .i_start  (w_start),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_id),
    .o_any    (w_pick_any)
  );

`ifdef MUTEX_RR_EN
  logic [ID_W-1:0] r_ptr;

  // Next search begins just past whoever won last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_pick_id == ID_W'(N-1)) ? '0 : w_pick_id + 1'b1;
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  generate
    if (HOLD_MAX > 0) begin : g_hold
      localparam int CNT_W = id_w(HOLD_MAX);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (r_state == HELD) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_expire = (r_state == HELD) && (r_cnt == CNT_W'(HOLD_MAX-1));
    end else begin : g_no_hold
      assign w_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_mask    <= w_mask_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_timeout_nxt = 1'b0;
    // A mask bit survives only while its request stays high.
    w_mask_nxt    = r_mask & bus.req;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_gnt_nxt    = w_pick_oh;
          w_gnt_id_nxt = w_pick_id;
          w_state_nxt  = HELD;
        end
      end
      HELD: begin
        if (!w_owner_req) begin
          w_gnt_nxt    = '0;
          w_gnt_id_nxt = '0;
          w_state_nxt  = IDLE;
        end else if (w_expire) begin
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = '0;
          w_mask_nxt    = w_mask_nxt | r_gnt;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = |r_gnt;
  assign bus.timeout = r_timeout;

endmodule

`default_nettype wire

// File: doc/mutex_grant_n.md
# mutex_grant_n

Single-clock, N-channel first-come-wins mutual-exclusion grant latch; the parametrised successor of our two-party cross-locking request flops. Once a channel wins, it holds exclusive ownership until it drops its request or an optional hold timeout expires. Same-cycle ties resolve deterministically. Sits between shared-resource requesters and the resource mux, which uses `gnt_id` as its select.

## Interface
- `N`, 4: number of requesting channels, 2..32.
- `HOLD_MAX`, 0: maximum cycles a channel may hold the grant; 0 means unlimited (timeout logic absent).
- `ID_W`, $clog2(N) (minimum 1): width of `gnt_id`; derived, not overridden.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  N  per-channel request level; high means request or hold.
- `gnt`  out  N  one-hot grant; all-zero when idle. Registered.
- `gnt_id`  out  ID_W  index of the owner; 0 when idle. Registered.
- `busy`  out  1  high while any grant is held; equals OR of `gnt`.
- `timeout`  out  1  one-cycle pulse when a hold is forcibly revoked.

## Operation
- FSM states: IDLE, HELD.
- IDLE: if any eligible `req` is high, pick a winner, load `gnt`/`gnt_id`, clear hold counter, go to HELD. Otherwise stay.
- Eligible means `req[i]=1` and `mask[i]=0`.
- HELD: if `req[owner]=0`, clear `gnt`, set `gnt_id=0`, and go to IDLE. Requests from other channels are ignored while HELD. They are not queued.
- Hold timeout applies only when `HOLD_MAX>0`. The counter increments each HELD cycle. At the HELD edge where the counter equals HOLD_MAX-1 with `req[owner]` still high: revoke the grant, set `mask[owner]=1`, pulse `timeout`, and go to IDLE.
- Mask: `mask[i]` clears on the first edge where `req[i]=0`. A timed-out channel must drop and re-raise `req` to compete again.
- Tie-break without the macro: lowest index among eligible channels wins.
- Reset: `gnt=0`, `gnt_id=0`, `busy=0`, `timeout=0`, `mask=0`, counter 0, state IDLE. Reset overrides every other condition on the same edge, including mid-hold.
- `req` is assumed synchronous to `clk`. Synchronisers are the requester's responsibility.

## Timing
- Grant latency: `req` high before edge k gives `gnt` high after edge k (1 cycle).
- Release: `req[owner]` low before edge k gives `gnt` low after edge k. The earliest new grant is after edge k+1, which guarantees a mandatory one-cycle idle gap.
- Timeout: owner granted at edge g loses the grant after edge g+HOLD_MAX. `timeout` is high for exactly that one cycle.
- Owner drops `req` on the same edge the timeout would fire: this is treated as a normal release. `timeout` stays 0 and no mask is set.
- `busy` is derived from registered `gnt` and adds no extra latency.

## Configuration
- `MUTEX_RR_EN` defined: ties use rotating priority. The search starts at (last owner + 1) mod N, and the pointer updates on every grant. The pointer resets to 0, so the first tie after reset goes to channel 0.
- `MUTEX_RR_EN` undefined: fixed lowest-index priority. No pointer register exists.

## Structure
- Package `mutex_pkg`: state enum (IDLE, HELD) and a helper function `id_w(n)` returning max(1, clog2(n)).
- Sub-module `mutex_pick`: combinational N-bit picker. Inputs are eligible vector and start index; outputs are one-hot and index. With the macro off it is tied to start=0.
- Top-level holds the FSM, counter, mask, and RR pointer.

## Test plan
Parameters N=4, HOLD_MAX=8.
- Reset, then `req=4'b0100` → after next edge `gnt=4'b0100`, `gnt_id=2`, `busy=1`. Raising `req[0]` while held leaves `gnt` unchanged.
- Owner drops `req[2]` while `req[0]` is already high → `gnt=0` for one cycle, then `gnt=4'b0001`.
- Tie with `req=4'b1010` from IDLE: → `gnt=4'b0010` without the macro. Under `MUTEX_RR_EN` the successive ties after release go 1, 3, 1.
- Channel 3 holds `req` continuously → `timeout` pulses 8 cycles after the grant and `gnt=0`. Channel 3 is not re-granted until it drops and re-raises `req`.
- Owner drops `req` on the same edge the counter hits 7 → `timeout=0` and no mask is set. An immediate re-request is granted after the idle gap.
- `rst` asserted mid-hold with `req` still high → after that edge all outputs are 0. On the following edge the grant is re-acquired by the lowest eligible channel.
